// File: rtl/uart_prog_loader.sv
// Serial program loader: receives a framed image over 8N1 UART, writes it into
// the instruction ROM and holds the CPU in reset until the checksum verifies.
module uart_prog_loader #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned ADDR_W       = 6,
  parameter int unsigned TIMEOUT_CLKS = 1_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              uart_rx,
  output logic              rom_we,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [31:0]       rom_wdata,
  output logic              cpu_rst_n,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned     CntW    = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] BitEnd  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] HalfEnd = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam int unsigned     Depth   = 1 << ADDR_W;

  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;
  typedef enum logic [2:0] {StIdle, StLen, StData, StCsum, StAbort} fr_state_e;

  // Receiver state
  logic            rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_e       rx_state_q, rx_state_d;
  logic [CntW-1:0] bit_cnt_q, bit_cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shreg_q, shreg_d;
  logic            byte_valid, frame_err;

  // Frame state
  fr_state_e   st_q, st_d;
  logic [7:0]  len_q, len_d, word_idx_q, word_idx_d, sum_q, sum_d;
  logic [1:0]  lane_q, lane_d;
  logic [31:0] asm_q, asm_d, to_cnt_q, to_cnt_d;
  logic        rom_we_q, rom_we_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [31:0] rom_wdata_q, rom_wdata_d;
  logic        busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic        hold_q, hold_d, cpu_rst_n_q, cpu_rst_n_d;
  logic        in_frame, to_hit, abort;

  // Two-flop synchronizer plus one delayed copy for falling-edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= uart_rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  // Receiver next state: start-bit qualify, 8 data bits LSB first, stop bit
  always_comb begin
    rx_state_d = rx_state_q;
    bit_cnt_d  = bit_cnt_q;
    bit_idx_d  = bit_idx_q;
    shreg_d    = shreg_q;
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    unique case (rx_state_q)
      RxIdle: begin
        // Edge, not level, so a line held low after a framing error cannot retrigger
        if (rx_prev_q && !rx_sync_q) begin
          bit_cnt_d  = '0;
          rx_state_d = RxStart;
        end
      end
      RxStart: begin
        if (bit_cnt_q == HalfEnd) begin
          bit_cnt_d  = '0;
          bit_idx_d  = '0;
          rx_state_d = rx_sync_q ? RxIdle : RxData;
        end else begin
          bit_cnt_d = bit_cnt_q + CntW'(1);
        end
      end
      RxData: begin
        if (bit_cnt_q == BitEnd) begin
          bit_cnt_d = '0;
          shreg_d   = {rx_sync_q, shreg_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) rx_state_d = RxStop;
        end else begin
          bit_cnt_d = bit_cnt_q + CntW'(1);
        end
      end
      RxStop: begin
        if (bit_cnt_q == BitEnd) begin
          rx_state_d = RxIdle;
          byte_valid = rx_sync_q;
          frame_err  = !rx_sync_q;
        end else begin
          bit_cnt_d = bit_cnt_q + CntW'(1);
        end
      end
      default: rx_state_d = RxIdle;
    endcase
  end

  // Receiver state register
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_q <= RxIdle;
      bit_cnt_q  <= '0;
      bit_idx_q  <= '0;
      shreg_q    <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      bit_cnt_q  <= bit_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shreg_q    <= shreg_d;
    end
  end

  assign in_frame = (st_q == StLen) || (st_q == StData) || (st_q == StCsum);
  assign to_hit   = (TIMEOUT_CLKS != 0) && (to_cnt_q == 32'(TIMEOUT_CLKS - 1));

  // Frame FSM next state and registered outputs
  always_comb begin
    st_d        = st_q;
    len_d       = len_q;
    word_idx_d  = word_idx_q;
    sum_d       = sum_q;
    lane_d      = lane_q;
    asm_d       = asm_q;
    to_cnt_d    = to_cnt_q;
    rom_we_d    = 1'b0;
    rom_addr_d  = rom_addr_q;
    rom_wdata_d = rom_wdata_q;
    busy_d      = busy_q;
    done_d      = done_q;
    err_d       = err_q;
    hold_d      = hold_q;
    abort       = 1'b0;
    if (in_frame) to_cnt_d = byte_valid ? '0 : to_cnt_q + 32'd1;
    unique case (st_q)
      StIdle: begin
        if (byte_valid && shreg_q == 8'hA5) begin
          st_d     = StLen;
          busy_d   = 1'b1;
          hold_d   = 1'b1;
          done_d   = 1'b0;
          err_d    = 1'b0;
          to_cnt_d = '0;
        end
      end
      StLen: begin
        if (byte_valid) begin
          if (shreg_q == 8'h00 || 32'(shreg_q) > Depth) begin
            abort = 1'b1;
          end else begin
            len_d      = shreg_q;
            word_idx_d = '0;
            lane_d     = '0;
            sum_d      = '0;
            st_d       = StData;
          end
        end
      end
      StData: begin
        if (byte_valid) begin
          sum_d                     = sum_q + shreg_q;
          lane_d                    = lane_q + 2'd1;
          asm_d[{lane_q, 3'b000} +: 8] = shreg_q;
          if (lane_q == 2'd3) begin
            rom_we_d    = 1'b1;
            rom_addr_d  = ADDR_W'(word_idx_q);
            rom_wdata_d = {shreg_q, asm_q[23:0]};
            word_idx_d  = word_idx_q + 8'd1;
            if (word_idx_q == 8'(len_q - 8'd1)) st_d = StCsum;
          end
        end
      end
      StCsum: begin
        if (byte_valid) begin
          if (shreg_q == sum_q) begin
            st_d   = StIdle;
            done_d = 1'b1;
            busy_d = 1'b0;
            hold_d = 1'b0;
          end else begin
            abort = 1'b1;
          end
        end
      end
      StAbort: st_d = StIdle;
      default: st_d = StIdle;
    endcase
    if (in_frame && !byte_valid && (frame_err || to_hit)) abort = 1'b1;
    if (abort) begin
      st_d   = StAbort;
      err_d  = 1'b1;
      busy_d = 1'b0;
    end
    // hold stays set after an abort so a partially written image never runs
    cpu_rst_n_d = !hold_d;
  end

  // Frame state and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q        <= StIdle;
      len_q       <= '0;
      word_idx_q  <= '0;
      sum_q       <= '0;
      lane_q      <= '0;
      asm_q       <= '0;
      to_cnt_q    <= '0;
      rom_we_q    <= 1'b0;
      rom_addr_q  <= '0;
      rom_wdata_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      hold_q      <= 1'b0;
      cpu_rst_n_q <= 1'b0;
    end else begin
      st_q        <= st_d;
      len_q       <= len_d;
      word_idx_q  <= word_idx_d;
      sum_q       <= sum_d;
      lane_q      <= lane_d;
      asm_q       <= asm_d;
      to_cnt_q    <= to_cnt_d;
      rom_we_q    <= rom_we_d;
      rom_addr_q  <= rom_addr_d;
      rom_wdata_q <= rom_wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      hold_q      <= hold_d;
      cpu_rst_n_q <= cpu_rst_n_d;
    end
  end

  assign rom_we    = rom_we_q;
  assign rom_addr  = rom_addr_q;
  assign rom_wdata = rom_wdata_q;
  assign cpu_rst_n = cpu_rst_n_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule
